dram_bank_write: RTL

Write-side companion to the DRAM bank read model. It accepts one write request at a time (row number plus 32-bit data) under a valid/ready handshake. It models open-page row-buffer timing (precharge, activate, write) and stores the data into a 16-row array. A registered debug read port exposes array contents so the bench can check writes without the read model.

---
 rtl/dram_bank_write.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dram_bank_write.sv
// Write side of the DRAM bank model: open-page timing plus a 2**ROW_W x DATA_W array.
// A registered debug port reads the array one cycle behind dbg_row.
module dram_bank_write #(
  parameter int ROW_W  = 4,
  parameter int DATA_W = 32,
  parameter int T_PRE  = 1,
  parameter int T_ACT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  row_num,
  input  logic [DATA_W-1:0] input_data,
  input  logic              input_valid,
  output logic              input_ready,
  output logic              write_done,
  input  logic [ROW_W-1:0]  dbg_row,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2**ROW_W;
  localparam int T_MAX = (T_PRE > T_ACT) ? T_PRE : T_ACT;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_WR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_row_open;
  logic               w_row_open_nxt;
  logic [ROW_W-1:0]   r_open_row;
  logic [ROW_W-1:0]   w_open_row_nxt;
  logic [ROW_W-1:0]   r_req_row;
  logic [DATA_W-1:0]  r_req_data;
  logic               r_done;
  logic [DATA_W-1:0]  r_dbg;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic w_accept;
  logic w_hit;
  logic w_closed;
  logic w_miss;
  logic w_we;

  assign input_ready = (r_state == S_IDLE);
  assign write_done  = r_done;
  assign dbg_data    = r_dbg;

  assign w_accept = input_valid && input_ready;
  assign w_hit    = r_row_open && (row_num == r_open_row);
  assign w_closed = !r_row_open;
  assign w_miss   = r_row_open && (row_num != r_open_row);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_row_open_nxt = r_row_open;
    w_open_row_nxt = r_open_row;
    w_we           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            w_hit: begin
              w_state_nxt = S_WR;
            end
            w_closed: begin
              w_state_nxt = S_ACT;
              w_cnt_nxt   = CNT_W'(T_ACT - 1);
            end
            w_miss: begin
              w_state_nxt = S_PRE;
              w_cnt_nxt   = CNT_W'(T_PRE - 1);
            end
          endcase
        end
      end
      S_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt    = S_ACT;
          w_row_open_nxt = 1'b0;
          w_cnt_nxt      = CNT_W'(T_ACT - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACT: begin
        if (r_cnt == '0) begin
          w_state_nxt    = S_WR;
          w_row_open_nxt = 1'b1;
          w_open_row_nxt = r_req_row;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WR: begin
        w_we        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_row_open <= 1'b0;
      r_open_row <= '0;
      r_req_row  <= '0;
      r_req_data <= '0;
      r_done     <= 1'b0;
      r_dbg      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_row_open <= w_row_open_nxt;
      r_open_row <= w_open_row_nxt;
      r_done     <= w_we;
      r_dbg      <= r_mem[dbg_row];
      if (w_accept) begin
        r_req_row  <= row_num;
        r_req_data <= input_data;
      end
    end
  end

  // Read-before-write on the debug port falls out of the non-blocking update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[r_req_row] <= r_req_data;
    end
  end

endmodule
